pwm_multi_ctrl: RTL and testbench
=================================

Name: pwm_multi_ctrl

Overview:
Multi-channel PWM generator for board-level housekeeping, covering fan drive, LED dimming and slow test clocks. It is the generalised successor of the single-channel fixed-setting fan controller and the fixed-ratio divider logic in the FPGA top. It adds:
- parametrised channel count and counter width
- runtime prescaler and period
- per-channel duty and polarity
- glitch-free shadowed configuration updates applied only at period boundaries

The block sits in the FPGA top, or behind a register file in the SoC, on the SoC clock.

Parameters:
NumChannels, 4, number of independent PWM outputs sharing one period counter
CntWidth, 16, width of period counter, period and duty values
PrescWidth, 8, width of prescaler divide value

Ports:
clk_i  input  1  SoC clock
rst_ni  input  1  reset; asynchronous, active-low
en_i  input  1  run enable; low forces idle
cfg_update_i  input  1  single-cycle pulse; sample presc_i, period_i, duty_i, polarity_i
presc_i  input  PrescWidth  prescaler value; tick every presc_i+1 clocks
period_i  input  CntWidth  period value; period length = period_i+1 ticks
duty_i  input  NumChannels x CntWidth  per-channel high-time in ticks
polarity_i  input  NumChannels  1 = output inverted; also sets the idle level
pwm_o  output  NumChannels  registered PWM outputs
period_tick_o  output  1  one-cycle pulse on the period wrap
cfg_pending_o  output  1  shadow config waiting for the next wrap

Behaviour:
- Reset:
  - all counters 0; FSM IDLE
  - active and pending config all zero
  - pwm_o=0, period_tick_o=0, cfg_pending_o=0
- FSM states:
  - IDLE: presc_q=0, cnt_q=0; pwm_o[i] driven to active polarity[i] (idle level).
  - IDLE->RUN when en_i=1. The first tick occurs presc+1 cycles after entry.
  - RUN: any cycle with en_i=0 returns to IDLE on the next edge; counters clear, pwm_o goes idle on that edge. There is no drain.
- Prescaler:
  - presc_q increments each RUN cycle.
  - When presc_q==presc_active: tick=1 and presc_q<=0.
  - presc_active=0 gives a tick every cycle.
- Period counter:
  - On a tick, cnt_q increments.
  - On a tick with cnt_q==period_active: cnt_q<=0 and wrap=1.
  - period_active=0 means a wrap on every tick.
- Channel compare: raw[i] = (cnt_q < duty_active[i]), unsigned compare at CntWidth.
  - duty=0: always low.
  - duty > period: always high.
- Output: pwm_o[i] <= RUN ? raw[i]^pol_active[i] : pol_active[i]. One cycle of latency from cnt_q.
- period_tick_o: registered version of wrap, so it is 1 cycle after the wrap edge and aligned with pwm_o.
- Config capture, on cfg_update_i=1:
  - In IDLE: sampled values are written directly into active; cfg_pending_o stays 0.
  - In RUN without wrap in the same cycle: values go into pending and cfg_pending_o<=1.
  - A second update while pending overwrites pending; the last one wins.
  - In RUN with wrap in the same cycle: sampled values go directly to active; pending is cleared.
- Wrap with pending set: pending is copied to active and cfg_pending_o<=0. The new values take effect from cnt_q=0 of the next period, so there are no runt pulses.
- Disabling with pending set: pending is applied on entry to IDLE and cfg_pending_o clears.
- All arithmetic is unsigned.
  - Counters wrap only via the compare, never by overflow; cnt_q never exceeds period_active.
  - If the period is shrunk mid-period, it takes effect only at the wrap, so cnt_q cannot exceed the new period.
- Asynchronous reset mid-period returns everything to the reset values immediately.

Decomposition:
- Package pwm_pkg:
  - pwm_cfg_t struct: presc, period, duty array, polarity. The active and pending registers are both of this type.
  - State enum pwm_state_e {IDLE, RUN}.
- Sub-module pwm_channel, instantiated per channel:
  - inputs: cnt, duty, polarity, run
  - registered pwm output
- The top holds the prescaler, the period counter, the FSM and the shadow logic.

Test Plan:
1. Basic waveform: reset, update in IDLE with presc=0, period=9, duty[0]=3, pol=0; then en=1. Expect:
   - pwm_o[0] = 3 cycles high / 7 cycles low, repeating
   - period_tick_o every 10 cycles
2. Duty extremes: duty[1]=0, duty[2]=10, duty[3]=5 with period=9. Expect pwm_o[1] constant 0, pwm_o[2] constant 1, pwm_o[3] 50% duty.
3. Prescaler and polarity: presc=1, period=9, duty[0]=3, pol[0]=1. Expect:
   - a 20-cycle period with 6 cycles low and 14 high
   - pwm_o[0]=1 while en=0
4. Shadowed update: while running, update to duty[0]=8 mid-period. Expect:
   - cfg_pending_o=1 until the wrap
   - the current period keeps 3 high; the next period has 8 high
   - no pulse shorter than 3 cycles
5. Update coinciding with the wrap cycle: the new config is active from the following period; cfg_pending_o never asserts.
6. Disable and reset: deassert en_i mid-high, then pulse rst_ni low mid-period. Expect:
   - pwm_o at the idle level one cycle after en_i falls
   - counters at 0
   - after reset, the active config is zero and all outputs are 0

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM block.
// The configuration record is sized here, so the module parameters must keep these defaults.
package pwm_pkg;

    localparam int PwmChannels   = 4;
    localparam int PwmCntWidth   = 16;
    localparam int PwmPrescWidth = 8;

    typedef struct packed {
        logic [PwmPrescWidth-1:0]                presc;
        logic [PwmCntWidth-1:0]                  period;
        logic [PwmChannels-1:0][PwmCntWidth-1:0] duty;
        logic [PwmChannels-1:0]                  polarity;
    } pwm_cfg_t;

    typedef enum logic {
        IDLE,
        RUN
    } pwm_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: compares the shared period count against this channel's duty.
module pwm_channel #(
    parameter int CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CntWidth-1:0] cnt,
    input  logic [CntWidth-1:0] duty,
    input  logic                polarity,
    input  logic                run,
    output logic                pwm
);

    // When stopped the output rests at the polarity level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else if (run) begin
            pwm <= (cnt < duty) ^ polarity;
        end else begin
            pwm <= polarity;
        end
    end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator: prescaler, shared period counter, run/idle FSM and
// shadowed configuration that only takes effect at period boundaries.
module pwm_multi_ctrl
    import pwm_pkg::*;
#(
    parameter int NumChannels = PwmChannels,
    parameter int CntWidth    = PwmCntWidth,
    parameter int PrescWidth  = PwmPrescWidth
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                en_i,
    input  logic                                cfg_update_i,
    input  logic [PrescWidth-1:0]               presc_i,
    input  logic [CntWidth-1:0]                 period_i,
    input  logic [NumChannels-1:0][CntWidth-1:0] duty_i,
    input  logic [NumChannels-1:0]              polarity_i,
    output logic [NumChannels-1:0]              pwm_o,
    output logic                                period_tick_o,
    output logic                                cfg_pending_o
);

    pwm_state_e            state;
    logic [PrescWidth-1:0] presc_q;
    logic [CntWidth-1:0]   cnt_q;
    pwm_cfg_t              active;
    pwm_cfg_t              pending;
    pwm_cfg_t              sampled;
    logic                  run;
    logic                  tick;
    logic                  wrap;

    assign sampled = '{presc: presc_i, period: period_i, duty: duty_i, polarity: polarity_i};

    // A cycle with en_i low in RUN already counts as stopped, so no tick or wrap fires there.
    assign run  = (state == RUN) && en_i;
    assign tick = run && (presc_q == active.presc);
    assign wrap = tick && (cnt_q == active.period);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            presc_q       <= '0;
            cnt_q         <= '0;
            active        <= '0;
            pending       <= '0;
            cfg_pending_o <= 1'b0;
            period_tick_o <= 1'b0;
        end else begin
            period_tick_o <= wrap;
            case (state)
                IDLE: begin
                    presc_q <= '0;
                    cnt_q   <= '0;
                    if (cfg_update_i) begin
                        active <= sampled;
                    end
                    if (en_i) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en_i) begin
                        // Leaving RUN flushes any shadowed config; a same-cycle update is newer still.
                        state         <= IDLE;
                        presc_q       <= '0;
                        cnt_q         <= '0;
                        cfg_pending_o <= 1'b0;
                        if (cfg_update_i) begin
                            active <= sampled;
                        end else if (cfg_pending_o) begin
                            active <= pending;
                        end
                    end else begin
                        presc_q <= tick ? '0 : presc_q + 1'b1;
                        if (tick) begin
                            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
                        end
                        if (cfg_update_i && wrap) begin
                            active        <= sampled;
                            cfg_pending_o <= 1'b0;
                        end else if (cfg_update_i) begin
                            pending       <= sampled;
                            cfg_pending_o <= 1'b1;
                        end else if (wrap && cfg_pending_o) begin
                            active        <= pending;
                            cfg_pending_o <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NumChannels; i++) begin : g_ch
        pwm_channel #(
            .CntWidth(CntWidth)
        ) u_channel (
            .clk     (clk_i),
            .rst_n   (rst_ni),
            .cnt     (cnt_q),
            .duty    (active.duty[i]),
            .polarity(active.polarity[i]),
            .run     (run),
            .pwm     (pwm_o[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Self-checking bench for pwm_multi_ctrl; expectations come from a clock-position model of each period.
module tb_pwm_multi_ctrl;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             en_i;
    logic             cfg_update_i;
    logic [7:0]       presc_i;
    logic [15:0]      period_i;
    logic [3:0][15:0] duty_i;
    logic [3:0]       polarity_i;
    logic [3:0]       pwm_o;
    logic             period_tick_o;
    logic             cfg_pending_o;

    int checks = 0;
    int errors = 0;

    pwm_multi_ctrl dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .en_i         (en_i),
        .cfg_update_i (cfg_update_i),
        .presc_i      (presc_i),
        .period_i     (period_i),
        .duty_i       (duty_i),
        .polarity_i   (polarity_i),
        .pwm_o        (pwm_o),
        .period_tick_o(period_tick_o),
        .cfg_pending_o(cfg_pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int presc;
        int period;
        int duty[4];
        bit pol[4];
    } cfg_t;

    cfg_t       m_act, m_pnd;
    bit         m_pend_f, m_running, m_wrap;
    int         m_pos, m_len, m_c;
    logic [3:0] exp_pwm;
    logic       exp_tick, exp_pend;

    function automatic cfg_t zero_cfg();
        cfg_t c;
        c.presc = 0;
        c.period = 0;
        for (int i = 0; i < 4; i++) begin
            c.duty[i] = 0;
            c.pol[i] = 1'b0;
        end
        return c;
    endfunction

    function automatic cfg_t sample_cfg();
        cfg_t c;
        c.presc = int'(presc_i);
        c.period = int'(period_i);
        for (int i = 0; i < 4; i++) begin
            c.duty[i] = int'(duty_i[i]);
            c.pol[i] = polarity_i[i];
        end
        return c;
    endfunction

    // Reference: m_pos is the clock index inside the period; a period is (presc+1)*(period+1) clocks.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_act = zero_cfg();
            m_pnd = zero_cfg();
            m_pend_f = 1'b0;
            m_running = 1'b0;
            m_pos = 0;
            exp_pwm = 4'b0;
            exp_tick = 1'b0;
            exp_pend = 1'b0;
        end else begin
            if (m_running && en_i) begin
                m_len = (m_act.presc + 1) * (m_act.period + 1);
                m_c = m_pos / (m_act.presc + 1);
                for (int i = 0; i < 4; i++) exp_pwm[i] = (m_c < m_act.duty[i]) ^ m_act.pol[i];
                m_wrap = (m_pos == m_len - 1);
                exp_tick = m_wrap;
                m_pos = m_wrap ? 0 : m_pos + 1;
                if (cfg_update_i) begin
                    if (m_wrap) begin
                        m_act = sample_cfg();
                        m_pend_f = 1'b0;
                    end else begin
                        m_pnd = sample_cfg();
                        m_pend_f = 1'b1;
                    end
                end else if (m_wrap && m_pend_f) begin
                    m_act = m_pnd;
                    m_pend_f = 1'b0;
                end
            end else begin
                for (int i = 0; i < 4; i++) exp_pwm[i] = m_act.pol[i];
                exp_tick = 1'b0;
                if (cfg_update_i) m_act = sample_cfg();
                else if (m_pend_f) m_act = m_pnd;
                m_pend_f = 1'b0;
                m_running = !m_running && en_i;
                m_pos = 0;
            end
            exp_pend = m_pend_f;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, need finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_cfg(input int presc, input int period, input int d0, input int d1,
                           input int d2, input int d3, input logic [3:0] pol);
        presc_i = 8'(presc);
        period_i = 16'(period);
        duty_i[0] = 16'(d0);
        duty_i[1] = 16'(d1);
        duty_i[2] = 16'(d2);
        duty_i[3] = 16'(d3);
        polarity_i = pol;
    endtask

    task automatic pulse_update();
        cfg_update_i = 1'b1;
        @(negedge clk_i);
        cfg_update_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        en_i = 1'b0;
        cfg_update_i = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 4'b0);
        #12;
        if ({pwm_o, period_tick_o, cfg_pending_o} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b need=000000", {pwm_o, period_tick_o, cfg_pending_o});
        end
        checks++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        if ({pwm_o, period_tick_o, cfg_pending_o} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle got=%b need=000000", {pwm_o, period_tick_o, cfg_pending_o});
        end
        checks++;
    endtask

    task automatic test_basic();
        int highs = 0, ticks = 0;
        set_cfg(0, 9, 3, 0, 0, 0, 4'b0);
        pulse_update();
        en_i = 1'b1;
        repeat (2) @(negedge clk_i);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            highs += int'(pwm_o[0]);
            ticks += int'(period_tick_o);
            if ({pwm_o, period_tick_o, cfg_pending_o} !== {exp_pwm, exp_tick, exp_pend}) begin
                errors++;
                $display("[TB] FAIL basic_model t=%0t got=%b need=%b", $time,
                         {pwm_o, period_tick_o, cfg_pending_o}, {exp_pwm, exp_tick, exp_pend});
            end
            checks++;
        end
        if (highs !== 9) begin
            errors++;
            $display("[TB] FAIL basic_high_count got=%0d need=9", highs);
        end
        checks++;
        if (ticks !== 3) begin
            errors++;
            $display("[TB] FAIL basic_tick_count got=%0d need=3", ticks);
        end
        checks++;
    endtask

    task automatic test_duty_extremes();
        int h1 = 0, h2 = 0, h3 = 0;
        en_i = 1'b0;
        @(negedge clk_i);
        set_cfg(0, 9, 3, 0, 10, 5, 4'b0);
        pulse_update();
        en_i = 1'b1;
        repeat (2) @(negedge clk_i);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            h1 += int'(pwm_o[1]);
            h2 += int'(pwm_o[2]);
            h3 += int'(pwm_o[3]);
            if ({pwm_o, period_tick_o, cfg_pending_o} !== {exp_pwm, exp_tick, exp_pend}) begin
                errors++;
                $display("[TB] FAIL extremes_model t=%0t got=%b need=%b", $time,
                         {pwm_o, period_tick_o, cfg_pending_o}, {exp_pwm, exp_tick, exp_pend});
            end
            checks++;
        end
        if (h1 !== 0 || h2 !== 30 || h3 !== 15) begin
            errors++;
            $display("[TB] FAIL extremes_counts got=%0d/%0d/%0d need=0/30/15", h1, h2, h3);
        end
        checks++;
    endtask

    task automatic test_presc_polarity();
        int lows = 0;
        en_i = 1'b0;
        @(negedge clk_i);
        set_cfg(1, 9, 3, 0, 10, 5, 4'b0001);
        pulse_update();
        @(negedge clk_i);
        if (pwm_o[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_polarity got=%b need=1", pwm_o[0]);
        end
        checks++;
        en_i = 1'b1;
        repeat (2) @(negedge clk_i);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            lows += int'(!pwm_o[0]);
            if ({pwm_o, period_tick_o, cfg_pending_o} !== {exp_pwm, exp_tick, exp_pend}) begin
                errors++;
                $display("[TB] FAIL presc_model t=%0t got=%b need=%b", $time,
                         {pwm_o, period_tick_o, cfg_pending_o}, {exp_pwm, exp_tick, exp_pend});
            end
            checks++;
        end
        if (lows !== 12) begin
            errors++;
            $display("[TB] FAIL presc_low_count got=%0d need=12", lows);
        end
        checks++;
    endtask

    task automatic test_shadow_update();
        int highs, waited;
        bit seen_tick = 1'b0;
        en_i = 1'b0;
        @(negedge clk_i);
        set_cfg(0, 9, 3, 0, 10, 5, 4'b0);
        pulse_update();
        en_i = 1'b1;
        waited = 0;
        while (!(m_running && m_pos == 1) && waited < 40) begin
            @(negedge clk_i);
            waited++;
        end
        highs = int'(pwm_o[0]);
        set_cfg(0, 9, 8, 0, 10, 5, 4'b0);
        pulse_update();
        for (int k = 0; k < 30 && !seen_tick; k++) begin
            highs += int'(pwm_o[0]);
            seen_tick = period_tick_o;
            if (cfg_pending_o !== !period_tick_o) begin
                errors++;
                $display("[TB] FAIL shadow_pending t=%0t got=%b need=%b", $time, cfg_pending_o, !period_tick_o);
            end
            checks++;
            if (!seen_tick) @(negedge clk_i);
        end
        if (!seen_tick) begin
            errors++;
            $display("[TB] FAIL shadow_wrap_timeout got=no_tick need=tick");
        end
        checks++;
        if (highs !== 3) begin
            errors++;
            $display("[TB] FAIL shadow_old_high got=%0d need=3", highs);
        end
        checks++;
        highs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            highs += int'(pwm_o[0]);
            if ({pwm_o, period_tick_o, cfg_pending_o} !== {exp_pwm, exp_tick, exp_pend}) begin
                errors++;
                $display("[TB] FAIL shadow_model t=%0t got=%b need=%b", $time,
                         {pwm_o, period_tick_o, cfg_pending_o}, {exp_pwm, exp_tick, exp_pend});
            end
            checks++;
        end
        if (highs !== 8) begin
            errors++;
            $display("[TB] FAIL shadow_new_high got=%0d need=8", highs);
        end
        checks++;
    endtask

    task automatic test_update_at_wrap();
        int highs = 0, pends = 0, waited = 0;
        while (!(m_running && m_pos == 9) && waited < 40) begin
            @(negedge clk_i);
            waited++;
        end
        set_cfg(0, 9, 6, 0, 10, 5, 4'b0);
        pulse_update();
        pends += int'(cfg_pending_o);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            highs += int'(pwm_o[0]);
            pends += int'(cfg_pending_o);
            if ({pwm_o, period_tick_o, cfg_pending_o} !== {exp_pwm, exp_tick, exp_pend}) begin
                errors++;
                $display("[TB] FAIL wrap_update_model t=%0t got=%b need=%b", $time,
                         {pwm_o, period_tick_o, cfg_pending_o}, {exp_pwm, exp_tick, exp_pend});
            end
            checks++;
        end
        if (pends !== 0) begin
            errors++;
            $display("[TB] FAIL wrap_update_pending got=%0d need=0", pends);
        end
        checks++;
        if (highs !== 6) begin
            errors++;
            $display("[TB] FAIL wrap_update_high got=%0d need=6", highs);
        end
        checks++;
    endtask

    task automatic test_disable_reset();
        int waited = 0;
        while (pwm_o[0] !== 1'b1 && waited < 40) begin
            @(negedge clk_i);
            waited++;
        end
        en_i = 1'b0;
        @(negedge clk_i);
        if (pwm_o !== 4'b0000 || period_tick_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL disable_idle got=%b%b need=00000", pwm_o, period_tick_o);
        end
        checks++;
        if (dut.cnt_q !== 16'd0 || dut.presc_q !== 8'd0) begin
            errors++;
            $display("[TB] FAIL disable_counters got=%0d/%0d need=0/0", dut.cnt_q, dut.presc_q);
        end
        checks++;
        en_i = 1'b1;
        repeat (6) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        if ({pwm_o, period_tick_o, cfg_pending_o} !== 6'b0 || dut.cnt_q !== 16'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got=%b cnt=%0d need=000000 cnt=0",
                     {pwm_o, period_tick_o, cfg_pending_o}, dut.cnt_q);
        end
        checks++;
        en_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        en_i = 1'b1;
        repeat (3) @(negedge clk_i);
        if (pwm_o !== 4'b0 || period_tick_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_zero_cfg got=%b%b need=00001", pwm_o, period_tick_o);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 80; k++) begin
                en_i = ($urandom_range(0, 99) < 95);
                cfg_update_i = (k == 0) || ($urandom_range(0, 99) < 5);
                if (cfg_update_i)
                    set_cfg($urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 15),
                            $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                            4'($urandom));
                @(negedge clk_i);
                if ({pwm_o, period_tick_o, cfg_pending_o} !== {exp_pwm, exp_tick, exp_pend}) begin
                    errors++;
                    $display("[TB] FAIL random_model t=%0t got=%b need=%b", $time,
                             {pwm_o, period_tick_o, cfg_pending_o}, {exp_pwm, exp_tick, exp_pend});
                end
                checks++;
            end
        end
        cfg_update_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_extremes();
        test_presc_polarity();
        test_shadow_update();
        test_update_at_wrap();
        test_disable_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
